ref_sched: RTL and testbench
============================

# ref_sched

Refresh scheduler for the DDR controller core. While main control reports the memory is initialised and idle, it generates one refresh credit per tREFI. It borrows the DFI command bus from the transaction engine through a req/gnt handshake, then issues a precharge-all followed by an auto-refresh. It tracks postponed refreshes and escalates to urgent before the JEDEC postponement limit is exceeded.

## Interface
Parameters:
- TREFI_CYC, 1560, refresh interval in core_clk cycles
- TRP_CYC, 4, precharge-to-command wait in core_clk cycles (≥1)
- TRFC_CYC, 44, refresh-to-command wait in core_clk cycles (≥1)
- MAX_POSTPONE, 8, debt at which ref_urgent asserts
- ADDR_W, 14, DFI address width
- BANK_W, 3, DFI bank width
- CS_W, 1, chip-select width

Ports:
- One clock; reset is asynchronous and active-low.
- core_clk  in  1  core clock
- core_arstn  in  1  async active-low reset
- enable  in  1  high while main control is in IDLE; refresh counting allowed
- ref_req  out  1  request ownership of the DFI command bus
- ref_urgent  out  1  debt ≥ MAX_POSTPONE; grantor must grant at next burst boundary
- ref_gnt  in  1  bus granted to this block
- ref_busy  out  1  a PREA/REF sequence is in progress
- ref_debt  out  4  outstanding refresh count, 0..MAX_POSTPONE+1
- ref_overflow  out  1  sticky: a tick arrived while debt was already MAX_POSTPONE+1
- dfi_cs_n  out  CS_W  command chip-selects (phase 0)
- dfi_ras_n, dfi_cas_n, dfi_we_n  out  1 each  command strobes
- dfi_address  out  ADDR_W  address (A10 = all-bank)
- dfi_bank  out  BANK_W  bank address

## Operation
- Interval counter: counts 0..TREFI_CYC-1 while enable=1. At TREFI_CYC-1 it wraps and pulses tick. enable=0 holds it at 0.
- Debt: tick increments it, saturating at MAX_POSTPONE+1; a tick at saturation sets ref_overflow. A completed refresh decrements it. A simultaneous tick and completion leaves debt unchanged.
- enable=0 clears debt to 0 only while the FSM is in IDLE. If a sequence is running, debt clears after it finishes. ref_overflow clears only on reset.
- FSM states:
  - IDLE → REQ when debt>0 and enable=1.
  - REQ (ref_req=1) → PREA when ref_gnt=1.
  - PREA (1 cycle) → WAIT_RP.
  - WAIT_RP (TRP_CYC cycles) → REF.
  - REF (1 cycle) → WAIT_RFC.
  - WAIT_RFC (TRFC_CYC cycles) → DONE.
  - DONE (1 cycle: debt decrement, ref_req=0) → IDLE.
- enable falling while in REQ: withdraw ref_req and return to IDLE. Once PREA is issued, the sequence always completes.
- Handshake rules:
  - ref_req stays high from REQ entry through the WAIT_RFC exit.
  - The grantor holds ref_gnt high until ref_req drops, and drives ref_gnt=0 whenever ref_req=0.
  - ref_gnt seen while not in REQ is ignored.
- One refresh per grant. If debt remains, the FSM re-requests from IDLE on the next cycle, which lets transactions interleave.
- Command encodings:
  - PREA: cs_n=0, ras_n=0, cas_n=1, we_n=0, address[10]=1, other bits 0.
  - REF: cs_n=0, ras_n=0, cas_n=0, we_n=1.
  - All other cycles (NOP/deselect): cs_n all 1, strobes 1, address 0, bank 0.
- All chip-selects are driven together.
- ref_busy=1 in states PREA through DONE. ref_urgent = (debt ≥ MAX_POSTPONE).

## Timing
- Reset values: ref_req=0, ref_urgent=0, ref_busy=0, ref_debt=0, ref_overflow=0, dfi_cs_n all 1, ras_n/cas_n/we_n=1, address=0, bank=0. FSM=IDLE, counters 0.
- Reset mid-sequence aborts immediately to these values.
- All outputs are registered.
- After enable rises, the first tick occurs TREFI_CYC cycles later. Debt is visible the cycle after the tick; ref_req the cycle after that.
- ref_gnt sampled high at edge N: PREA command is on the bus during cycle N+1.
- REF appears TRP_CYC+1 cycles after PREA.
- ref_req falls TRFC_CYC+1 cycles after REF; the debt decrement is visible on the same edge.

## Structure
- Package ref_pkg holds:
  - the state enum typedef;
  - a dfi_cmd_t struct {cs_n, ras_n, cas_n, we_n, address, bank};
  - constants CMD_NOP, CMD_PREA, CMD_REF, built by a function of ADDR_W/BANK_W/CS_W.
- One natural sub-module: ref_timer, a reloadable down-counter with done pulse. It is instantiated once and loaded with TRP_CYC or TRFC_CYC. The interval counter is inline.

## Test plan
- TREFI_CYC=100, TRP=4, TRFC=20, ref_gnt tied to ref_req delayed 1 cycle, enable high → tick at cycle 100. Checks: PREA on bus, REF exactly 5 cycles after PREA, ref_req falls 21 cycles after REF, debt returns 0.
- ref_gnt held 0 for 900 cycles → debt climbs to 8, ref_urgent rises at the 8th tick. A 9th tick gives debt 9; a 10th tick sets ref_overflow, debt stays 9.
- Grant restored after debt=9 → nine back-to-back sequences, each separated by a 2-cycle ref_req low gap. ref_urgent drops when debt reaches 7.
- Tick landing in the DONE cycle with debt=1 → debt stays 1 and a new request follows.
- enable dropped during WAIT_RP → REF and WAIT_RFC still complete, then debt=0. enable dropped in REQ → ref_req falls next cycle with no command issued.
- core_arstn asserted during WAIT_RFC → all outputs take their reset values asynchronously. After release, no command appears until a new tick.

Source files
------------

// File: rtl/ref_pkg.sv
// Shared types and DFI command constants for the refresh scheduler.
package ref_pkg;

  localparam int unsigned MAX_ADDR_W = 32;
  localparam int unsigned MAX_BANK_W = 8;
  localparam int unsigned MAX_CS_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_PREA     = 3'd2,
    S_WAIT_RP  = 3'd3,
    S_REF      = 3'd4,
    S_WAIT_RFC = 3'd5,
    S_DONE     = 3'd6
  } ref_state_e;

  // Sized for the widest supported bus; the top slices down to its own widths.
  typedef struct packed {
    logic [MAX_CS_W-1:0]   cs_n;
    logic                  ras_n;
    logic                  cas_n;
    logic                  we_n;
    logic [MAX_ADDR_W-1:0] address;
    logic [MAX_BANK_W-1:0] bank;
  } dfi_cmd_t;

  function automatic dfi_cmd_t mk_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n,
                                      input logic a10);
    dfi_cmd_t c;
    c.cs_n        = {MAX_CS_W{cs_n}};
    c.ras_n       = ras_n;
    c.cas_n       = cas_n;
    c.we_n        = we_n;
    c.address     = {MAX_ADDR_W{1'b0}};
    c.address[10] = a10;
    c.bank        = {MAX_BANK_W{1'b0}};
    return c;
  endfunction

  localparam dfi_cmd_t CMD_NOP  = mk_cmd(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  localparam dfi_cmd_t CMD_PREA = mk_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  localparam dfi_cmd_t CMD_REF  = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

endpackage

// File: rtl/ref_timer.sv
// Reloadable down-counter; o_done is high during the last cycle of the loaded interval.
module ref_timer #(
  parameter int unsigned W = 6
) (
  input  logic         i_clk,
  input  logic         i_arstn,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Load or count down, parking at zero.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != W'(0)) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/ref_sched.sv
// Refresh scheduler: accrues one refresh credit per tREFI, borrows the DFI bus
// and issues PREA then REF for each credit, escalating when debt grows.
module ref_sched
  import ref_pkg::*;
#(
  parameter int unsigned TREFI_CYC    = 1560,
  parameter int unsigned TRP_CYC      = 4,
  parameter int unsigned TRFC_CYC     = 44,
  parameter int unsigned MAX_POSTPONE = 8,
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned BANK_W       = 3,
  parameter int unsigned CS_W         = 1
) (
  input  logic              core_clk,
  input  logic              core_arstn,
  input  logic              enable,
  output logic              ref_req,
  output logic              ref_urgent,
  input  logic              ref_gnt,
  output logic              ref_busy,
  output logic [3:0]        ref_debt,
  output logic              ref_overflow,
  output logic [CS_W-1:0]   dfi_cs_n,
  output logic              dfi_ras_n,
  output logic              dfi_cas_n,
  output logic              dfi_we_n,
  output logic [ADDR_W-1:0] dfi_address,
  output logic [BANK_W-1:0] dfi_bank
);

  localparam int unsigned TMR_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned CNT_W   = $clog2(TREFI_CYC);
  localparam logic [3:0]  DEBT_SAT = 4'(MAX_POSTPONE + 1);
  localparam logic [3:0]  DEBT_URG = 4'(MAX_POSTPONE);

  logic [CNT_W-1:0]  r_ivl_cnt;
  logic              w_tick;
  ref_state_e        r_state, w_state_nxt;
  logic              w_tmr_load, w_tmr_done, w_complete;
  logic [TMR_W-1:0]  w_tmr_val;
  logic [3:0]        r_debt, w_debt_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_req, r_urgent, r_busy;
  logic [CS_W-1:0]   r_cs_n, w_cs_n_nxt;
  logic              r_ras_n, r_cas_n, r_we_n, w_ras_n_nxt, w_cas_n_nxt, w_we_n_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [BANK_W-1:0] r_bank, w_bank_nxt;

  assign w_tick = enable && (r_ivl_cnt == CNT_W'(TREFI_CYC - 1));

  // tREFI interval counter, held at zero while disabled.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      r_ivl_cnt <= '0;
    end else if (!enable || w_tick) begin
      r_ivl_cnt <= '0;
    end else begin
      r_ivl_cnt <= r_ivl_cnt + CNT_W'(1);
    end
  end

  ref_timer #(.W(TMR_W)) u_timer (
    .i_clk   (core_clk),
    .i_arstn (core_arstn),
    .i_load  (w_tmr_load),
    .i_val   (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  // Sequence FSM next state; enable is only honoured before PREA goes out.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = TMR_W'(TRP_CYC);
    case (r_state)
      S_IDLE:     if (enable && (r_debt != 4'd0)) w_state_nxt = S_REQ; else w_state_nxt = S_IDLE;
      S_REQ:      if (!enable) w_state_nxt = S_IDLE;
                  else if (ref_gnt) w_state_nxt = S_PREA;
                  else w_state_nxt = S_REQ;
      S_PREA:     begin
                    w_state_nxt = S_WAIT_RP;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(TRP_CYC);
                  end
      S_WAIT_RP:  if (w_tmr_done) w_state_nxt = S_REF; else w_state_nxt = S_WAIT_RP;
      S_REF:      begin
                    w_state_nxt = S_WAIT_RFC;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(TRFC_CYC);
                  end
      S_WAIT_RFC: if (w_tmr_done) w_state_nxt = S_DONE; else w_state_nxt = S_WAIT_RFC;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  assign w_complete = (r_state == S_WAIT_RFC) && w_tmr_done;

  // Debt accounting: a tick and a completion in the same cycle cancel out.
  always_comb begin
    w_debt_nxt = r_debt;
    w_ovf_nxt  = r_ovf;
    if ((r_state == S_IDLE) && !enable) begin
      w_debt_nxt = 4'd0;
    end else if (w_tick && !w_complete) begin
      if (r_debt == DEBT_SAT) w_ovf_nxt = 1'b1; else w_debt_nxt = r_debt + 4'd1;
    end else if (!w_tick && w_complete && (r_debt != 4'd0)) begin
      w_debt_nxt = r_debt - 4'd1;
    end else begin
      w_debt_nxt = r_debt;
    end
  end

  // Command for the cycle after the coming edge.
  always_comb begin
    w_cs_n_nxt  = CMD_NOP.cs_n[CS_W-1:0];
    w_ras_n_nxt = CMD_NOP.ras_n;
    w_cas_n_nxt = CMD_NOP.cas_n;
    w_we_n_nxt  = CMD_NOP.we_n;
    w_addr_nxt  = CMD_NOP.address[ADDR_W-1:0];
    w_bank_nxt  = CMD_NOP.bank[BANK_W-1:0];
    case (w_state_nxt)
      S_PREA: begin
        w_cs_n_nxt  = CMD_PREA.cs_n[CS_W-1:0];
        w_ras_n_nxt = CMD_PREA.ras_n;
        w_cas_n_nxt = CMD_PREA.cas_n;
        w_we_n_nxt  = CMD_PREA.we_n;
        w_addr_nxt  = CMD_PREA.address[ADDR_W-1:0];
        w_bank_nxt  = CMD_PREA.bank[BANK_W-1:0];
      end
      S_REF: begin
        w_cs_n_nxt  = CMD_REF.cs_n[CS_W-1:0];
        w_ras_n_nxt = CMD_REF.ras_n;
        w_cas_n_nxt = CMD_REF.cas_n;
        w_we_n_nxt  = CMD_REF.we_n;
        w_addr_nxt  = CMD_REF.address[ADDR_W-1:0];
        w_bank_nxt  = CMD_REF.bank[BANK_W-1:0];
      end
      default: begin
        w_cs_n_nxt  = CMD_NOP.cs_n[CS_W-1:0];
        w_addr_nxt  = CMD_NOP.address[ADDR_W-1:0];
      end
    endcase
  end

  // State, debt and output registers; outputs follow the next state so they align with it.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      r_state  <= S_IDLE;
      r_debt   <= 4'd0;
      r_ovf    <= 1'b0;
      r_req    <= 1'b0;
      r_urgent <= 1'b0;
      r_busy   <= 1'b0;
      r_cs_n   <= {CS_W{1'b1}};
      r_ras_n  <= 1'b1;
      r_cas_n  <= 1'b1;
      r_we_n   <= 1'b1;
      r_addr   <= '0;
      r_bank   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_debt   <= w_debt_nxt;
      r_ovf    <= w_ovf_nxt;
      r_req    <= w_state_nxt inside {S_REQ, S_PREA, S_WAIT_RP, S_REF, S_WAIT_RFC};
      r_urgent <= (w_debt_nxt >= DEBT_URG);
      r_busy   <= w_state_nxt inside {S_PREA, S_WAIT_RP, S_REF, S_WAIT_RFC, S_DONE};
      r_cs_n   <= w_cs_n_nxt;
      r_ras_n  <= w_ras_n_nxt;
      r_cas_n  <= w_cas_n_nxt;
      r_we_n   <= w_we_n_nxt;
      r_addr   <= w_addr_nxt;
      r_bank   <= w_bank_nxt;
    end
  end

  assign ref_req      = r_req;
  assign ref_urgent   = r_urgent;
  assign ref_busy     = r_busy;
  assign ref_debt     = r_debt;
  assign ref_overflow = r_ovf;
  assign dfi_cs_n     = r_cs_n;
  assign dfi_ras_n    = r_ras_n;
  assign dfi_cas_n    = r_cas_n;
  assign dfi_we_n     = r_we_n;
  assign dfi_address  = r_addr;
  assign dfi_bank     = r_bank;

endmodule

// File: tb/tb_ref_sched.sv
// Directed bench for ref_sched with TREFI=100, TRP=4, TRFC=20; sample points are negedges.
module tb_ref_sched;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned BANK_W = 3;
  localparam int unsigned CS_W   = 1;

  logic              core_clk   = 1'b0;
  logic              core_arstn = 1'b1;
  logic              enable     = 1'b0;
  logic              ref_gnt    = 1'b0;
  logic              gnt_en     = 1'b0;
  logic              ref_req, ref_urgent, ref_busy, ref_overflow;
  logic [3:0]        ref_debt;
  logic [CS_W-1:0]   dfi_cs_n;
  logic              dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [ADDR_W-1:0] dfi_address;
  logic [BANK_W-1:0] dfi_bank;

  int n_cmp = 0;
  int n_bad = 0;
  int now   = 0;
  logic saw_cmd;

  ref_sched #(
    .TREFI_CYC(100), .TRP_CYC(4), .TRFC_CYC(20), .MAX_POSTPONE(8),
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .CS_W(CS_W)
  ) dut (
    .core_clk(core_clk), .core_arstn(core_arstn), .enable(enable),
    .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_gnt(ref_gnt),
    .ref_busy(ref_busy), .ref_debt(ref_debt), .ref_overflow(ref_overflow),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n),
    .dfi_we_n(dfi_we_n), .dfi_address(dfi_address), .dfi_bank(dfi_bank)
  );

  always #5 core_clk = ~core_clk;

  // Grantor: follows ref_req just after each edge when granting is allowed.
  always @(posedge core_clk) begin
    #1;
    ref_gnt = gnt_en & ref_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // exp_strb = {cs_n, ras_n, cas_n, we_n}
  task automatic chk_cmd(input string tag, input logic [3:0] exp_strb, input logic [ADDR_W-1:0] exp_addr);
    logic es;
    es = exp_strb[3];
    chk({tag, "_strb"}, 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}),
        32'({{CS_W{es}}, exp_strb[2:0]}));
    chk({tag, "_addr"}, 32'(dfi_address), 32'(exp_addr));
    chk({tag, "_bank"}, 32'(dfi_bank), 32'd0);
  endtask

  task automatic go(input int k);
    while (now < k) begin
      @(negedge core_clk);
      now++;
    end
  endtask

  task automatic restart();
    @(negedge core_clk);
    enable = 1'b0; gnt_en = 1'b0; core_arstn = 1'b0;
    @(negedge core_clk);
    @(negedge core_clk);
    core_arstn = 1'b1;
    @(negedge core_clk);
    enable = 1'b1;
    now = 0;
  endtask

  initial begin
    // Reset values
    #2 core_arstn = 1'b0;
    @(negedge core_clk);
    chk("rst_req", 32'(ref_req), 32'd0);
    chk("rst_busy", 32'(ref_busy), 32'd0);
    chk("rst_debt", 32'(ref_debt), 32'd0);
    chk("rst_ovf", 32'(ref_overflow), 32'd0);
    chk("rst_urg", 32'(ref_urgent), 32'd0);
    chk_cmd("rst_cmd", 4'b1111, 14'h0000);

    // Basic sequence
    restart();
    gnt_en = 1'b1;
    go(99);  chk("p1_debt_99", 32'(ref_debt), 32'd0);
    go(100); chk("p1_debt_100", 32'(ref_debt), 32'd1); chk("p1_req_100", 32'(ref_req), 32'd0);
    go(101); chk("p1_req_101", 32'(ref_req), 32'd1); chk("p1_busy_101", 32'(ref_busy), 32'd0);
    go(102); chk_cmd("p1_prea", 4'b0010, 14'h0400); chk("p1_busy_102", 32'(ref_busy), 32'd1);
    go(106); chk_cmd("p1_nop_106", 4'b1111, 14'h0000);
    go(107); chk_cmd("p1_ref", 4'b0001, 14'h0000);
    go(127); chk("p1_req_127", 32'(ref_req), 32'd1);
    go(128); chk("p1_req_128", 32'(ref_req), 32'd0); chk("p1_debt_128", 32'(ref_debt), 32'd0);
             chk("p1_busy_128", 32'(ref_busy), 32'd1);
    go(129); chk("p1_busy_129", 32'(ref_busy), 32'd0);

    // Grant withheld: debt climbs to saturation and overflow
    gnt_en = 1'b0;
    go(899);  chk("p2_debt_899", 32'(ref_debt), 32'd7); chk("p2_urg_899", 32'(ref_urgent), 32'd0);
    go(900);  chk("p2_debt_900", 32'(ref_debt), 32'd8); chk("p2_urg_900", 32'(ref_urgent), 32'd1);
    go(1000); chk("p2_debt_1000", 32'(ref_debt), 32'd9); chk("p2_ovf_1000", 32'(ref_overflow), 32'd0);
    go(1100); chk("p2_debt_1100", 32'(ref_debt), 32'd9); chk("p2_ovf_1100", 32'(ref_overflow), 32'd1);
              chk("p2_req_1100", 32'(ref_req), 32'd1);

    // Grant restored: back-to-back sequences with 2-cycle req gap
    gnt_en = 1'b1;
    go(1102); chk_cmd("p3_prea0", 4'b0010, 14'h0400);
    go(1128); chk("p3_req_1128", 32'(ref_req), 32'd0); chk("p3_debt_1128", 32'(ref_debt), 32'd8);
              chk("p3_urg_1128", 32'(ref_urgent), 32'd1);
    go(1129); chk("p3_req_1129", 32'(ref_req), 32'd0);
    go(1130); chk("p3_req_1130", 32'(ref_req), 32'd1);
    go(1131); chk_cmd("p3_prea1", 4'b0010, 14'h0400);
    go(1156); chk("p3_urg_1156", 32'(ref_urgent), 32'd1);
    go(1157); chk("p3_debt_1157", 32'(ref_debt), 32'd7); chk("p3_urg_1157", 32'(ref_urgent), 32'd0);
              chk("p3_ovf_1157", 32'(ref_overflow), 32'd1);

    // Tick coinciding with completion
    restart();
    go(172); gnt_en = 1'b1;
    go(174); chk_cmd("p4_prea", 4'b0010, 14'h0400);
    go(199); chk("p4_debt_199", 32'(ref_debt), 32'd1);
    go(200); chk("p4_debt_200", 32'(ref_debt), 32'd1); chk("p4_req_200", 32'(ref_req), 32'd0);
    go(201); chk("p4_req_201", 32'(ref_req), 32'd0);
    go(202); chk("p4_req_202", 32'(ref_req), 32'd1);
    go(203); chk_cmd("p4_prea2", 4'b0010, 14'h0400);
    go(229); chk("p4_debt_229", 32'(ref_debt), 32'd0);

    // enable dropped during WAIT_RP: sequence still completes
    go(300); chk("p5_debt_300", 32'(ref_debt), 32'd1);
    go(302); chk_cmd("p5_prea", 4'b0010, 14'h0400);
    go(303); enable = 1'b0;
    go(307); chk_cmd("p5_ref", 4'b0001, 14'h0000);
    go(327); chk("p5_req_327", 32'(ref_req), 32'd1);
    go(328); chk("p5_req_328", 32'(ref_req), 32'd0); chk("p5_debt_328", 32'(ref_debt), 32'd0);
    go(329); chk("p5_busy_329", 32'(ref_busy), 32'd0);

    // enable dropped in REQ: request withdrawn, no command, debt cleared
    go(330); enable = 1'b1; gnt_en = 1'b0;
    go(430); chk("p5_debt_430", 32'(ref_debt), 32'd1);
    go(431); chk("p5_req_431", 32'(ref_req), 32'd1); enable = 1'b0;
    go(432); chk("p5_req_432", 32'(ref_req), 32'd0); chk_cmd("p5_nop_432", 4'b1111, 14'h0000);
    go(433); chk("p5_debt_433", 32'(ref_debt), 32'd0); chk("p5_busy_433", 32'(ref_busy), 32'd0);

    // Asynchronous reset during WAIT_RFC
    restart();
    gnt_en = 1'b1;
    go(110); chk("p6_busy_110", 32'(ref_busy), 32'd1);
    core_arstn = 1'b0;
    #1;
    chk("p6_req", 32'(ref_req), 32'd0);
    chk("p6_busy", 32'(ref_busy), 32'd0);
    chk("p6_debt", 32'(ref_debt), 32'd0);
    chk_cmd("p6_cmd", 4'b1111, 14'h0000);
    @(negedge core_clk);
    core_arstn = 1'b1;
    now = 0;
    saw_cmd = 1'b0;
    for (int i = 1; i < 100; i++) begin
      go(i);
      if (ref_req !== 1'b0 || dfi_cs_n !== {CS_W{1'b1}} || ref_busy !== 1'b0) saw_cmd = 1'b1;
    end
    chk("p6_quiet", 32'(saw_cmd), 32'd0);
    go(100); chk("p6_debt_100", 32'(ref_debt), 32'd1);
    go(101); chk("p6_req_101", 32'(ref_req), 32'd1);
    go(102); chk_cmd("p6_prea", 4'b0010, 14'h0400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
